mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
Multi-cycle MIPS control unit. Successor to the single-cycle combinational decoder: a state machine sequences FETCH/DECODE/EXEC/MEM/WB, handshakes with instruction/data memory, counts retired instructions and traps illegal encodings. It sits between the instruction register and the multi-cycle datapath (PC, IR, register file, ALU, memory).

Parameters:
ALUOP_W, 4, ALUOp width; fixed encoding below, upper bits zero if widened.
TIMEOUT, 15, max cycles waiting for mem_ack before FAULT; 0 disables the watchdog.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-high.
Op  in  6  opcode from IR; valid from DECODE onward.
Funct  in  6  funct from IR; valid from DECODE onward.
Zero  in  1  ALU zero flag; sampled in EXEC.
mem_ack  in  1  memory completion for the current mem_req.
mem_req  out  1  memory access request, held until mem_ack.
PCWrite  out  1  PC load enable.
IRWrite  out  1  IR load enable.
RegWrite  out  1  register file write.
MemWrite  out  1  data memory write, qualifies mem_req.
EXTOp  out  1  1 = sign-extend immediate.
ALUSrcA  out  1  1 = shamt, 0 = rs.
ALUSrc  out  1  1 = immediate, 0 = rt.
ALUOp  out  ALUOP_W  ALU operation.
NPCOp  out  2  00 PC+4, 01 branch, 10 jump(target), 11 jump register.
GPRSel  out  2  00 rd, 01 rt, 10 $31.
WDSel  out  2  00 ALU, 01 MEM, 10 PC+4.
state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, FAULT 7.
fault  out  1  sticky illegal-instruction / timeout flag.
retired  out  CNT_W  retired-instruction counter.

Behaviour:
- Reset: state=FETCH, fault=0, retired=0, wait counter=0; all control outputs 0 while rst=1. The first cycle after rst deassertion is FETCH.
- Outputs are decoded from the registered state plus Op/Funct (Moore in state, Mealy only on Zero in EXEC and mem_ack in FETCH/MEM).
- FETCH: mem_req=1. On mem_ack: IRWrite=1, PCWrite=1 (NPCOp=00), go to DECODE. Otherwise stay.
- DECODE: classify the instruction.
  - Illegal → FAULT.
  - j: PCWrite=1, NPCOp=10, retire → FETCH.
  - jr: PCWrite=1, NPCOp=11, retire → FETCH.
  - jal/jalr → WB.
  - All others → EXEC.
- EXEC: ALU signals per instruction.
  - beq/bne: ALUOp=SUB; PCWrite=(beq&Zero)|(bne&~Zero), NPCOp=01; retire → FETCH.
  - lw/sw: ALUOp=ADD, ALUSrc=1, EXTOp=1 → MEM.
  - Other ALU instructions → WB.
- MEM: mem_req=1, MemWrite=sw. On mem_ack: sw retires → FETCH; lw → WB.
- WB: RegWrite=1, one cycle, retire → FETCH.
  - R-type: GPRSel=00, WDSel=00.
  - addi/ori/andi/slti/lui: GPRSel=01, WDSel=00.
  - lw: GPRSel=01, WDSel=01.
  - jal: GPRSel=10, WDSel=10, PCWrite=1, NPCOp=10.
  - jalr: GPRSel=00, WDSel=10, PCWrite=1, NPCOp=11.
- Cycle counts (zero-wait memory): j/jr 2; beq/bne 3; jal/jalr 3; sw 4; ALU 4; lw 5. Each cycle without mem_ack adds one.
- Legal set:
  - R (Op=0): add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, xor 100110, nor 100111, slt 101010, sltu 101011, sll 000000, srl 000010, sra 000011, sllv 000100, srlv 000110, srav 000111, jr 001000, jalr 001001.
  - I: addi 001000, slti 001010, andi 001100, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101.
  - J: j 000010, jal 000011.
- EXTOp=1 for addi, slti, lw, sw, beq, bne. andi/ori/lui use zero extension.
- ALUOp: NOP 0, ADD 1, SUB 2, AND 3, OR 4, SLT 5, SLTU 6, SLL 7, SRL 8, NOR 9, LUI 10, XOR 11, SRA 12, SLLV 13, SRLV 14, SRAV 15.
- ALUSrcA=1 for sll/srl/sra only. Add/addu map to ADD; sub/subu map to SUB.
- Watchdog: a counter increments each FETCH/MEM cycle without mem_ack and clears on mem_ack or state change. Reaching TIMEOUT → FAULT.
- FAULT: all controls 0, fault=1; only rst exits.
- retired increments by 1 in each retiring cycle and wraps at 2^CNT_W.
- rst mid-access: mem_req drops in the next cycle; partial instruction does not retire.

Test Plan:
- rst 2 cycles, mem_ack tied 1, IR=addi $t0,$0,5 (0x20080005) → states 0,1,2,4; WB: RegWrite=1, GPRSel=01, EXTOp=1, ALUOp=1; retired=1.
- lw 0x8C090004, mem_ack delayed 3 cycles in MEM → 8-cycle instruction, MemWrite=0, WDSel=01 in WB, retired increments once.
- beq with Zero=1, then Zero=0 → PCWrite=1/NPCOp=01, then PCWrite=0; both take 3 cycles.
- jal 0x0C000010 → DECODE→WB: RegWrite=1, GPRSel=10, WDSel=10, PCWrite=1, NPCOp=10.
- Op=111111 → FAULT at DECODE+1; fault=1 held 20 cycles; rst clears to FETCH, retired=0.
- mem_ack held 0 in FETCH, TIMEOUT=15 → FAULT after 15 cycles. TIMEOUT=0 → waits indefinitely.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit.
// Sequences FETCH/DECODE/EXEC/MEM/WB, handshakes with memory, counts retired instructions, traps illegal ops.
module mc_ctrl #(
  parameter int ALUOP_W = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               EXTOp,
  output logic               ALUSrcA,
  output logic               ALUSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         NPCOp,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic [2:0]         state,
  output logic               fault,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    C_ILLEGAL, C_ALU_R, C_ALU_I, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JR, C_JAL, C_JALR
  } class_e;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_NOR  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;
  localparam logic [3:0] ALU_XOR  = 4'd11;
  localparam logic [3:0] ALU_SRA  = 4'd12;
  localparam logic [3:0] ALU_SLLV = 4'd13;
  localparam logic [3:0] ALU_SRLV = 4'd14;
  localparam logic [3:0] ALU_SRAV = 4'd15;

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  class_e     ins_class;
  logic [3:0] alu_code;
  logic       alu_src, alu_src_a, ext_op;
  logic       mem_wait, timeout_hit, retire;

  // Instruction classification and ALU field decode from the IR opcode/funct.
  always_comb begin
    ins_class = C_ILLEGAL;
    alu_code  = ALU_NOP;
    alu_src   = 1'b0;
    alu_src_a = 1'b0;
    ext_op    = 1'b0;
    case (Op)
      6'b000000: begin
        ins_class = C_ALU_R;
        case (Funct)
          6'b100000, 6'b100001: alu_code = ALU_ADD;
          6'b100010, 6'b100011: alu_code = ALU_SUB;
          6'b100100: alu_code = ALU_AND;
          6'b100101: alu_code = ALU_OR;
          6'b100110: alu_code = ALU_XOR;
          6'b100111: alu_code = ALU_NOR;
          6'b101010: alu_code = ALU_SLT;
          6'b101011: alu_code = ALU_SLTU;
          6'b000000: begin alu_code = ALU_SLL; alu_src_a = 1'b1; end
          6'b000010: begin alu_code = ALU_SRL; alu_src_a = 1'b1; end
          6'b000011: begin alu_code = ALU_SRA; alu_src_a = 1'b1; end
          6'b000100: alu_code = ALU_SLLV;
          6'b000110: alu_code = ALU_SRLV;
          6'b000111: alu_code = ALU_SRAV;
          6'b001000: ins_class = C_JR;
          6'b001001: ins_class = C_JALR;
          default:   ins_class = C_ILLEGAL;
        endcase
      end
      6'b001000: begin ins_class = C_ALU_I; alu_code = ALU_ADD; alu_src = 1'b1; ext_op = 1'b1; end
      6'b001010: begin ins_class = C_ALU_I; alu_code = ALU_SLT; alu_src = 1'b1; ext_op = 1'b1; end
      6'b001100: begin ins_class = C_ALU_I; alu_code = ALU_AND; alu_src = 1'b1; end
      6'b001101: begin ins_class = C_ALU_I; alu_code = ALU_OR;  alu_src = 1'b1; end
      6'b001111: begin ins_class = C_ALU_I; alu_code = ALU_LUI; alu_src = 1'b1; end
      6'b100011: begin ins_class = C_LW;    alu_code = ALU_ADD; alu_src = 1'b1; ext_op = 1'b1; end
      6'b101011: begin ins_class = C_SW;    alu_code = ALU_ADD; alu_src = 1'b1; ext_op = 1'b1; end
      6'b000100: begin ins_class = C_BEQ;   alu_code = ALU_SUB; ext_op = 1'b1; end
      6'b000101: begin ins_class = C_BNE;   alu_code = ALU_SUB; ext_op = 1'b1; end
      6'b000010: ins_class = C_J;
      6'b000011: ins_class = C_JAL;
      default:   ins_class = C_ILLEGAL;
    endcase
  end

  assign mem_wait    = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ack;
  assign timeout_hit = (TIMEOUT != 0) && mem_wait && (wait_q == WAIT_LAST);

  // Next-state and control outputs; reset forces every control low.
  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    mem_req  = 1'b0;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    EXTOp    = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = '0;
    NPCOp    = 2'b00;
    GPRSel   = 2'b00;
    WDSel    = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        case (ins_class)
          C_ILLEGAL:      state_d = S_FAULT;
          C_J:            begin PCWrite = 1'b1; NPCOp = 2'b10; retire = 1'b1; state_d = S_FETCH; end
          C_JR:           begin PCWrite = 1'b1; NPCOp = 2'b11; retire = 1'b1; state_d = S_FETCH; end
          C_JAL, C_JALR:  state_d = S_WB;
          default:        state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        ALUOp   = ALUOP_W'(alu_code);
        ALUSrc  = alu_src;
        ALUSrcA = alu_src_a;
        EXTOp   = ext_op;
        case (ins_class)
          C_BEQ:      begin NPCOp = 2'b01; PCWrite = Zero;  retire = 1'b1; state_d = S_FETCH; end
          C_BNE:      begin NPCOp = 2'b01; PCWrite = !Zero; retire = 1'b1; state_d = S_FETCH; end
          C_LW, C_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        MemWrite = (ins_class == C_SW);
        if (mem_ack) begin
          if (ins_class == C_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
        ALUOp    = ALUOP_W'(alu_code);
        ALUSrc   = alu_src;
        ALUSrcA  = alu_src_a;
        EXTOp    = ext_op;
        case (ins_class)
          C_ALU_I: GPRSel = 2'b01;
          C_LW:    begin GPRSel = 2'b01; WDSel = 2'b01; end
          C_JAL:   begin GPRSel = 2'b10; WDSel = 2'b10; PCWrite = 1'b1; NPCOp = 2'b10; end
          C_JALR:  begin WDSel = 2'b10; PCWrite = 1'b1; NPCOp = 2'b11; end
          default: ;
        endcase
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
    if (rst) begin
      retire   = 1'b0;
      mem_req  = 1'b0;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      EXTOp    = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrc   = 1'b0;
      ALUOp    = '0;
      NPCOp    = 2'b00;
      GPRSel   = 2'b00;
      WDSel    = 2'b00;
    end
  end

  // Watchdog counts consecutive unacknowledged cycles within one FETCH or MEM visit.
  always_comb begin
    wait_d = '0;
    if ((TIMEOUT != 0) && mem_wait && (state_d == state_q)) begin
      wait_d = wait_q + 1'b1;
    end
    retired_d = retired_q + CNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign fault   = (state_q == S_FAULT);
  assign retired = retired_q;

endmodule
